// File: rtl/fifo_lb_pkg.sv
// Shared types and constants for the FIFO loopback checker.
// The LFSR constants below are used only when FIFO_LB_PRBS_EN is defined.
package fifo_lb_pkg;

    // Run sequencing states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } lb_state_t;

    // Fibonacci LFSR x^32 + x^22 + x^2 + x + 1: the feedback is the XOR of state bits 31, 21, 1 and 0
    localparam int          LFSR_W        = 32;
    localparam logic [31:0] LFSR_TAPS     = 32'h8020_0003;
    // An all-zero state would lock the LFSR, so a zero seed is replaced by this value
    localparam logic [31:0] LFSR_ZERO_SUB = 32'h0000_0001;

    // Consecutive stall cycles before a run is abandoned
    localparam int          DEF_TIMEOUT   = 64;

    // Advance the LFSR by one step: shift left and insert the feedback bit at bit 0
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/fifo_lb_pattern.sv
// Pattern source for the loopback checker. It produces the word for the current index.
// "load" rewinds the source to index 0, and "step" advances it by one word.
// If FIFO_LB_PRBS_EN is defined, the source is a 32-bit LFSR seeded from BASE.
// Otherwise it is an incrementing count that starts at BASE and wraps modulo 2^DW.
module fifo_lb_pattern
    import fifo_lb_pkg::*;
#(
    parameter int          DW   = 8,
    parameter logic [31:0] BASE = 32'h40
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    output logic [DW-1:0] value
);

`ifdef FIFO_LB_PRBS_EN
    // Only the low DW bits of BASE form the seed
    localparam logic [31:0] MASK = 32'((64'h1 << DW) - 64'h1);
    localparam logic [31:0] SEED = ((BASE & MASK) == 32'h0) ? LFSR_ZERO_SUB : (BASE & MASK);

    logic [LFSR_W-1:0] r_lfsr;

    // LFSR state: reseeded at run start, one shift per word
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_lfsr <= '0;
        else if (load)
            r_lfsr <= SEED;
        else if (step)
            r_lfsr <= lfsr_next(r_lfsr);
    end

    assign value = r_lfsr[DW-1:0];
`else
    logic [DW-1:0] r_cnt;

    // Incrementing pattern: BASE at run start, then +1 per word, wrapping naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (load)
            r_cnt <= BASE[DW-1:0];
        else if (step)
            r_cnt <= r_cnt + DW'(1);
    end

    assign value = r_cnt;
`endif

endmodule

// File: rtl/fifo_loopback_checker.sv
// FIFO loopback traffic generator and checker.
// A run writes len pattern words into an external FIFO, reads them all back and compares
// every returned word with the expected pattern. At the end it reports done, pass,
// timeout and a saturating mismatch count.
// Optional macro FIFO_LB_PRBS_EN selects the LFSR pattern instead of the incrementing one.
// Ports and timing are the same with or without the macro.
module fifo_loopback_checker
    import fifo_lb_pkg::*;
#(
    parameter int          DW      = 8,
    parameter int          MAX_LEN = 16,
    parameter logic [31:0] BASE    = 32'h40,
    parameter int          RD_LAT  = 1,
    parameter int          TIMEOUT = DEF_TIMEOUT,
    parameter int          CW      = 16,
    localparam int         LW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] cfg_len,
    input  logic          fifo_full,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_dout,
    output logic          fifo_wr_en,
    output logic [DW-1:0] fifo_din,
    output logic          fifo_rd_en,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [CW-1:0] err_cnt
);

    localparam int            SW        = $clog2(TIMEOUT + 1);
    localparam logic [LW-1:0] MAX_L     = LW'(MAX_LEN);
    localparam logic [SW-1:0] STALL_LIM = SW'(TIMEOUT - 1);

    lb_state_t       r_state;
    lb_state_t       w_next;

    logic [LW-1:0]   r_len;
    logic [LW-1:0]   r_wr_idx;
    logic [LW-1:0]   r_rd_idx;
    logic [LW-1:0]   r_chk_idx;
    logic [SW-1:0]   r_stall_cnt;
    logic [RD_LAT-1:0] r_vld_pipe;
    logic [CW-1:0]   r_err_cnt;
    logic            r_pass;
    logic            r_timeout;

    logic [LW-1:0]   w_len_in;
    logic [RD_LAT-1:0] w_vld_nxt;
    logic            w_load;
    logic            w_wr_en;
    logic            w_rd_en;
    logic            w_stall;
    logic            w_abort;
    logic            w_chk_vld;
    logic            w_chk_last;
    logic            w_mismatch;
    logic [DW-1:0]   w_wr_pat;
    logic [DW-1:0]   w_chk_pat;

    // Requested lengths above MAX_LEN are clamped
    assign w_len_in = (cfg_len > MAX_L) ? MAX_L : cfg_len;

    // A stall is a cycle in which the current phase wants to move but the FIFO blocks it.
    // Once stall_cnt reaches TIMEOUT-1, the stall in that cycle is the TIMEOUT-th in a row
    // and the run is abandoned.
    assign w_stall = ((r_state == ST_WRITE) && fifo_full) ||
                     ((r_state == ST_READ)  && fifo_empty);
    assign w_abort = w_stall && (r_stall_cnt == STALL_LIM);

    // Read data becomes valid RD_LAT cycles after the rd_en that requested it
    assign w_chk_vld  = r_vld_pipe[RD_LAT-1];
    assign w_mismatch = w_chk_vld && (fifo_dout != w_chk_pat);
    assign w_chk_last = w_chk_vld && (r_chk_idx == r_len - LW'(1));

    if (RD_LAT == 1) begin : g_lat1
        assign w_vld_nxt = w_rd_en;
    end else begin : g_latn
        assign w_vld_nxt = {r_vld_pipe[RD_LAT-2:0], w_rd_en};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic and FIFO strobes. Each strobe depends only on the state and the
    // FIFO flags, so wr_en and rd_en can never both be high.
    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_wr_en = 1'b0;
        w_rd_en = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = (w_len_in == '0) ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_wr_en = !fifo_full;
                if (w_abort)
                    w_next = ST_DONE;
                else if (w_wr_en && (r_wr_idx == r_len - LW'(1)))
                    w_next = ST_READ;
            end
            ST_READ: begin
                w_rd_en = !fifo_empty;
                if (w_abort)
                    w_next = ST_DONE;
                else if (w_rd_en && (r_rd_idx == r_len - LW'(1)))
                    w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_chk_last || (r_chk_idx == r_len))
                    w_next = ST_DONE;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Run datapath: indices, read-valid pipe, stall counter, error count and result flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len       <= '0;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_chk_idx   <= '0;
            r_stall_cnt <= '0;
            r_vld_pipe  <= '0;
            r_err_cnt   <= '0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            // When a run is abandoned, any reads still in flight are dropped unchecked
            r_vld_pipe <= w_abort ? '0 : w_vld_nxt;

            if (w_wr_en)
                r_wr_idx <= r_wr_idx + LW'(1);
            if (w_rd_en)
                r_rd_idx <= r_rd_idx + LW'(1);

            if (w_chk_vld) begin
                r_chk_idx <= r_chk_idx + LW'(1);
                if (w_mismatch && (r_err_cnt != '1))
                    r_err_cnt <= r_err_cnt + CW'(1);
            end

            if (w_stall && !w_abort)
                r_stall_cnt <= r_stall_cnt + SW'(1);
            else
                r_stall_cnt <= '0;

            if (w_abort)
                r_timeout <= 1'b1;

            if (r_state == ST_DONE)
                r_pass <= !r_timeout && (r_err_cnt == '0);

            // A new run clears the previous run's results
            if (w_load) begin
                r_len       <= w_len_in;
                r_wr_idx    <= '0;
                r_rd_idx    <= '0;
                r_chk_idx   <= '0;
                r_stall_cnt <= '0;
                r_err_cnt   <= '0;
                r_pass      <= 1'b0;
                r_timeout   <= 1'b0;
            end
        end
    end

    // Writer pattern advances on each accepted write; checker pattern advances on each check
    fifo_lb_pattern #(.DW(DW), .BASE(BASE)) u_wr_pat (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .step  (w_wr_en),
        .value (w_wr_pat)
    );

    fifo_lb_pattern #(.DW(DW), .BASE(BASE)) u_chk_pat (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .step  (w_chk_vld),
        .value (w_chk_pat)
    );

    assign fifo_wr_en = w_wr_en;
    assign fifo_din   = w_wr_pat;
    assign fifo_rd_en = w_rd_en;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign pass       = r_pass;
    assign timeout    = r_timeout;
    assign err_cnt    = r_err_cnt;

endmodule
